// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control
// Description : Per-stage stall generation with multi-cycle hold and flush
//               sequencing; optional stall watchdog (macro STALL_WATCHDOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control #(
    parameter int STAGES         = 6,
    parameter int HOLD_STAGE     = 3,
    parameter int HOLD_W         = 6,
    parameter int FLUSH_CYCLES   = 2,
    parameter int WATCHDOG_LIMIT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STAGES-1:0] stall_request,
    input  logic              hold_start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              flush_request,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic              hold_busy,
    output logic              watchdog_timeout
);

    localparam int c_FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LOAD = c_FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);

    generate
        if (STAGES < 2 || HOLD_STAGE >= STAGES || FLUSH_CYCLES < 1 || WATCHDOG_LIMIT < 1) begin : g_bad_params
            $error("pipeline_control: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } flush_state_t;

    flush_state_t          r_state;
    flush_state_t          w_state_nxt;
    logic [c_FLUSH_W-1:0]  r_flush_cnt;
    logic [c_FLUSH_W-1:0]  w_flush_cnt_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic                  w_flush;
    logic [STAGES-1:0]     w_req;
    logic [STAGES-1:0]     w_stall;
    logic                  w_acc;

    // Flush sequencer: a request (re)loads the remaining extra flush cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (flush_request) begin
            w_flush_cnt_nxt = c_FLUSH_LOAD;
            w_state_nxt     = (c_FLUSH_LOAD != '0) ? S_FLUSH : S_IDLE;
        end else if (r_state == S_FLUSH) begin
            w_flush_cnt_nxt = r_flush_cnt - c_FLUSH_ONE;
            if (r_flush_cnt <= c_FLUSH_ONE) begin
                w_state_nxt = S_IDLE;
            end
        end
        w_flush = !reset && (flush_request || (r_state == S_FLUSH));
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_hold_cnt <= '0;
        end else if (hold_start && (r_hold_cnt == '0) && (hold_len != '0)) begin
            r_hold_cnt <= hold_len;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

    // Thermometer fill: every stage at or below the highest requester stalls.
    always_comb begin
        w_req             = stall_request;
        w_req[HOLD_STAGE] = w_req[HOLD_STAGE] | hold_busy;
        w_acc             = 1'b0;
        w_stall           = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc      = w_acc | w_req[i];
            w_stall[i] = w_acc;
        end
        if (reset || w_flush) begin
            w_stall = '0;
        end
    end

    assign hold_busy = (r_hold_cnt != '0);
    assign stall     = w_stall;
    assign flush     = w_flush;

`ifdef STALL_WATCHDOG_EN
    localparam int c_WD_W = $clog2(WATCHDOG_LIMIT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(WATCHDOG_LIMIT);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_wd_timeout;
    logic              w_wd_active;

    assign w_wd_active = !w_flush && (w_stall != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt     <= '0;
            r_wd_timeout <= 1'b0;
        end else begin
            if (!w_wd_active) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_WD_LIMIT) begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
            end
            if (w_wd_active && (r_wd_cnt == c_WD_LIMIT - c_WD_W'(1))) begin
                r_wd_timeout <= 1'b1;
            end
        end
    end

    assign watchdog_timeout = r_wd_timeout;
`else
    assign watchdog_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_control
// Description : Directed self-checking bench for pipeline_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_control;

    logic       clock;
    logic       reset;
    logic [5:0] stall_request;
    logic       hold_start;
    logic [5:0] hold_len;
    logic       flush_request;
    logic [5:0] stall;
    logic       flush;
    logic       hold_busy;
    logic       watchdog_timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] vec_in  [4] = '{6'b001000, 6'b001100, 6'b000100, 6'b100001};
    logic [5:0] vec_exp [4] = '{6'b001111, 6'b001111, 6'b000111, 6'b111111};

`ifdef STALL_WATCHDOG_EN
    localparam logic c_WDT_EXP = 1'b1;
`else
    localparam logic c_WDT_EXP = 1'b0;
`endif

    pipeline_control dut (
        .clock            (clock),
        .reset            (reset),
        .stall_request    (stall_request),
        .hold_start       (hold_start),
        .hold_len         (hold_len),
        .flush_request    (flush_request),
        .stall            (stall),
        .flush            (flush),
        .hold_busy        (hold_busy),
        .watchdog_timeout (watchdog_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        stall_request = 6'b111111;
        hold_start    = 1'b0;
        hold_len      = 6'd0;
        flush_request = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        tick();
        tick();
        chk("rst_hold_busy", 32'(hold_busy), 32'h0);
        chk("rst_wdt", 32'(watchdog_timeout), 32'h0);
        reset         = 1'b0;
        stall_request = 6'b0;
        flush_request = 1'b0;
        #1;
        chk("idle_flush", 32'(flush), 32'h0);
        chk("idle_stall", 32'(stall), 32'h0);
        tick();

        // combinational stall vectors
        for (int i = 0; i < 4; i++) begin
            stall_request = vec_in[i];
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vec_exp[i]));
        end
        stall_request = 6'b0;
        tick();

        // 5-cycle hold; second pulse at cycle 2 ignored
        hold_start = 1'b1;
        hold_len   = 6'd5;
        #1;
        chk("hold_c0_busy", 32'(hold_busy), 32'h0);
        chk("hold_c0_stall", 32'(stall), 32'h0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            hold_start = (c == 2);
            hold_len   = (c == 2) ? 6'd9 : 6'd5;
            #1;
            chk($sformatf("hold_c%0d_busy", c), 32'(hold_busy), 32'h1);
            chk($sformatf("hold_c%0d_stall", c), 32'(stall), 32'h0f);
            tick();
        end
        hold_start = 1'b0;
        #1;
        chk("hold_c6_busy", 32'(hold_busy), 32'h0);
        chk("hold_c6_stall", 32'(stall), 32'h0);
        tick();

        // zero-length hold ignored
        hold_start = 1'b1;
        hold_len   = 6'd0;
        tick();
        hold_start = 1'b0;
        #1;
        chk("hold_len0_busy", 32'(hold_busy), 32'h0);
        tick();

        // flush during active hold
        hold_start = 1'b1;
        hold_len   = 6'd5;
        tick();
        hold_start = 1'b0;
        #1;
        chk("fh_busy_before", 32'(hold_busy), 32'h1);
        tick();
        stall_request = 6'b000100;
        flush_request = 1'b1;
        #1;
        chk("fh_c0_flush", 32'(flush), 32'h1);
        chk("fh_c0_stall", 32'(stall), 32'h0);
        tick();
        flush_request = 1'b0;
        #1;
        chk("fh_c1_flush", 32'(flush), 32'h1);
        chk("fh_c1_stall", 32'(stall), 32'h0);
        chk("fh_c1_busy", 32'(hold_busy), 32'h0);
        tick();
        chk("fh_c2_flush", 32'(flush), 32'h0);
        chk("fh_c2_stall", 32'(stall), 32'h07);
        chk("fh_c2_busy", 32'(hold_busy), 32'h0);
        stall_request = 6'b0;
        tick();

        // hold_start blocked by flush
        flush_request = 1'b1;
        hold_start    = 1'b1;
        hold_len      = 6'd4;
        tick();
        flush_request = 1'b0;
        hold_start    = 1'b0;
        #1;
        chk("hold_vs_flush_busy", 32'(hold_busy), 32'h0);
        tick();
        tick();

        // back-to-back flush requests extend the flush
        flush_request = 1'b1;
        #1;
        chk("bb_c0_flush", 32'(flush), 32'h1);
        tick();
        #1;
        chk("bb_c1_flush", 32'(flush), 32'h1);
        tick();
        flush_request = 1'b0;
        #1;
        chk("bb_c2_flush", 32'(flush), 32'h1);
        tick();
        chk("bb_c3_flush", 32'(flush), 32'h0);
        tick();

        // reset at cycle 2 of a 5-cycle hold
        hold_start = 1'b1;
        hold_len   = 6'd5;
        tick();
        hold_start = 1'b0;
        tick();
        reset         = 1'b1;
        stall_request = 6'b000010;
        #1;
        chk("rh_during_stall", 32'(stall), 32'h0);
        chk("rh_during_flush", 32'(flush), 32'h0);
        tick();
        chk("rh_edge_busy", 32'(hold_busy), 32'h0);
        chk("rh_edge_stall", 32'(stall), 32'h0);
        reset         = 1'b0;
        stall_request = 6'b0;
        tick();
        chk("rh_after_busy", 32'(hold_busy), 32'h0);
        chk("rh_after_stall", 32'(stall), 32'h0);
        chk("rh_after_flush", 32'(flush), 32'h0);
        tick();

        // reset mid-flush
        flush_request = 1'b1;
        tick();
        flush_request = 1'b0;
        reset         = 1'b1;
        #1;
        chk("rf_during_flush", 32'(flush), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rf_after_flush", 32'(flush), 32'h0);
        tick();

        // watchdog: 1023 cycles must not trip, 1024 must
        stall_request = 6'b000100;
        repeat (1023) tick();
        chk("wdt_1023", 32'(watchdog_timeout), 32'h0);
        stall_request = 6'b0;
        tick();
        chk("wdt_1023_after", 32'(watchdog_timeout), 32'h0);
        stall_request = 6'b000100;
        repeat (1023) tick();
        chk("wdt_pre_limit", 32'(watchdog_timeout), 32'h0);
        tick();
        chk("wdt_limit", 32'(watchdog_timeout), 32'(c_WDT_EXP));
        stall_request = 6'b0;
        tick();
        chk("wdt_sticky", 32'(watchdog_timeout), 32'(c_WDT_EXP));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("wdt_reset", 32'(watchdog_timeout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter STAGES, 6, number of pipeline stages (index 0 = pc, ascending toward writeback); SHALL be >= 2.
REQ-002 Parameter HOLD_STAGE, 3, stage index that owns the multi-cycle hold; SHALL be < STAGES.
REQ-003 Parameter HOLD_W, 6, width of the hold length field.
REQ-004 Parameter FLUSH_CYCLES, 2, total cycles flush is asserted per flush event; SHALL be >= 1.
REQ-005 Parameter WATCHDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 stall_request  input  STAGES  per-stage stall request, bit k from stage k.
REQ-009 hold_start  input  1  one-cycle pulse starting a multi-cycle hold.
REQ-010 hold_len  input  HOLD_W  hold length in cycles, sampled with hold_start.
REQ-011 flush_request  input  1  exception or redirect: flush the pipeline.
REQ-012 stall  output  STAGES  per-stage stall, bit k freezes stage k.
REQ-013 flush  output  1  pipeline flush.
REQ-014 hold_busy  output  1  high while a hold is in progress.
REQ-015 watchdog_timeout  output  1  sticky stall-timeout flag.

Function
REQ-016 Effective request vector SHALL be stall_request OR (hold_busy at bit HOLD_STAGE).
REQ-017 With k = highest set bit of the effective request vector, stall[i] SHALL be 1 for all i <= k and 0 for i > k; no request gives stall = 0. Stall is combinational, same cycle as the request.
REQ-018 flush SHALL be 1 combinationally in any cycle where flush_request = 1.
REQ-019 flush SHALL also be 1 for FLUSH_CYCLES-1 further cycles via a counter-driven FSM (IDLE, FLUSH). A flush_request edge loads FLUSH_CYCLES-1; the FSM enters FLUSH if that value is non-zero and decrements each cycle. It returns to IDLE at 0.
REQ-020 flush_request while in FLUSH SHALL reload the counter, extending the flush.
REQ-021 While flush = 1, stall SHALL be all zeros; flush takes priority over every stall source.
REQ-022 On a clock edge with hold_start = 1, hold_busy = 0, hold_len != 0 and flush = 0, the hold counter SHALL load hold_len. hold_busy = (counter != 0), registered; the counter decrements each cycle. hold_busy is therefore high for exactly hold_len cycles, starting the cycle after the pulse.
REQ-023 hold_start SHALL be ignored when hold_len = 0, while hold_busy = 1, or while flush = 1.
REQ-024 flush = 1 SHALL clear the hold counter at that clock edge; hold_busy is 0 from the next cycle.
REQ-025 stall_request bits are combinational inputs; no internal registering of them SHALL occur.

Reset
REQ-026 While reset = 1, stall = 0 and flush = 0 combinationally.
REQ-027 At a reset edge, the FSM returns to IDLE; flush, hold and watchdog counters clear to 0; hold_busy = 0; watchdog_timeout = 0.
REQ-028 Reset asserted mid-flush or mid-hold SHALL abort it with no residual assertion after reset release.

Configuration
REQ-029 Macro STALL_WATCHDOG_EN defined: a counter increments each cycle with stall != 0 and clears on any cycle with stall = 0 or flush = 1. It saturates at WATCHDOG_LIMIT; on reaching WATCHDOG_LIMIT, watchdog_timeout SHALL set at that edge and stay 1 until reset.
REQ-030 Macro STALL_WATCHDOG_EN undefined: no watchdog counter SHALL be instantiated and watchdog_timeout SHALL be constant 0.

Verification (default parameters)
REQ-031 stall_request = 6'b001000 -> stall = 6'b001111 same cycle; 6'b001100 -> 6'b001111; 6'b000100 -> 6'b000111; 6'b100001 -> 6'b111111.
REQ-032 hold_start pulse with hold_len = 5, no other requests -> hold_busy and stall = 6'b001111 for exactly cycles 1..5 after the pulse, then 0; a second hold_start at cycle 2 is ignored.
REQ-033 flush_request one cycle during active hold and stall_request = 6'b000100 -> flush = 1 for 2 cycles, stall = 0 in both, hold_busy = 0 from the following cycle.
REQ-034 flush_request pulses at cycles 0 and 1 -> flush high at cycles 0, 1 and 2, low at cycle 3.
REQ-035 STALL_WATCHDOG_EN defined, stall_request = 6'b000100 held 1024 cycles -> watchdog_timeout rises at edge 1024 and stays 1 after the request drops; release at 1023 cycles -> stays 0. Macro undefined -> always 0.
REQ-036 reset asserted at cycle 2 of a 5-cycle hold -> hold_busy = 0, stall = 0, flush = 0 after the reset edge and after reset release.
